pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipelined CPU. It replaces the separate hazard-detection and forwarding units. It keeps a shadow copy of the EX/MEM/WB destination state and produces:
- stall, bubble and flush controls for the IF/ID and ID/EX pipeline registers;
- 3:1 forwarding selects for both ALU operands;
- a whole-pipe freeze while data memory is not ready;
- a halt drain sequence.

It sits beside the Control block and is clocked with the pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, operand forwarding selects, memory-wait freeze and HLT
// drain sequencing for the 5-stage pipeline. Keeps its own shadow of EX/MEM/WB destination
// state so it can decide from current-cycle ID inputs alone.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BR_RESOLVE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_hlt,
  input  logic                  br_taken,
  input  logic                  mem_ready,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic                  freeze,
  output logic [1:0]            fwd_rs_sel,
  output logic [1:0]            fwd_rt_sel,
  output logic                  halted
);

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  rs_used;
    logic                  rt_used;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } ex_stage_t;

  // The load flag only matters while the load sits in EX, so it is not carried further.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } wr_stage_t;

  state_e    state_q, state_d;
  ex_stage_t ex_q, ex_d;
  wr_stage_t mem_q, mem_d;
  wr_stage_t wb_q, wb_d;

  logic frozen;
  logic br_flush;
  logic load_use;
  logic lu_rs_hit;
  logic lu_rt_hit;

  // A register that takes part in hazards/forwarding: anything unless r0 is hardwired zero.
  function automatic logic reg_live(input logic [REG_ADDR_W-1:0] r);
    return (ZERO_REG == 0) || (r != '0);
  endfunction

  assign frozen = ~rst & ~mem_ready;
  assign freeze = frozen;
  assign halted = (state_q == StHalted);

  // Hazard conditions seen from the ID instruction against the shadow EX entry.
  always_comb begin
    br_flush  = (BR_RESOLVE != 0) ? br_taken : (br_taken & id_valid);
    lu_rs_hit = id_valid & id_rs_used & (id_rs == ex_q.rd);
    lu_rt_hit = id_valid & id_rt_used & (id_rt == ex_q.rd);
    load_use  = ex_q.valid & ex_q.memread & ex_q.regwrite & reg_live(ex_q.rd) &
                (lu_rs_hit | lu_rt_hit);
  end

  // FSM next state and pipeline controls; flush beats load-use, which beats HLT acceptance.
  always_comb begin
    state_d     = state_q;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    if (!rst && !frozen) begin
      unique case (state_q)
        StRun: begin
          if (br_flush) begin
            flush_if_id = 1'b1;
            bubble_ex   = (BR_RESOLVE != 0);
          end else if (load_use) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
          end else if (id_valid && id_hlt) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
            state_d     = StDrain;
          end
        end
        StDrain: begin
          stall_if_id = 1'b1;
          bubble_ex   = 1'b1;
          // Once MEM is empty the last older instruction is in WB and retires on this edge.
          if (!mem_q.valid) begin
            state_d = StHalted;
          end
        end
        StHalted: begin
          stall_if_id = 1'b1;
          bubble_ex   = 1'b1;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Operand source selects from the held shadow; MEM result beats WB data.
  always_comb begin
    fwd_rs_sel = FwdRf;
    fwd_rt_sel = FwdRf;
    if (!rst) begin
      if (ex_q.rs_used && reg_live(ex_q.rs)) begin
        if (mem_q.valid && mem_q.regwrite && (mem_q.rd == ex_q.rs)) begin
          fwd_rs_sel = FwdMem;
        end else if (wb_q.valid && wb_q.regwrite && (wb_q.rd == ex_q.rs)) begin
          fwd_rs_sel = FwdWb;
        end
      end
      if (ex_q.rt_used && reg_live(ex_q.rt)) begin
        if (mem_q.valid && mem_q.regwrite && (mem_q.rd == ex_q.rt)) begin
          fwd_rt_sel = FwdMem;
        end else if (wb_q.valid && wb_q.regwrite && (wb_q.rd == ex_q.rt)) begin
          fwd_rt_sel = FwdWb;
        end
      end
    end
  end

  // Shadow advance: shift one stage per non-frozen edge, inserting a cleared entry on bubble.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!frozen) begin
      wb_d           = mem_q;
      mem_d.valid    = ex_q.valid;
      mem_d.rd       = ex_q.rd;
      mem_d.regwrite = ex_q.regwrite;
      if (id_valid && !bubble_ex && !flush_if_id) begin
        ex_d.valid    = 1'b1;
        ex_d.rs       = id_rs;
        ex_d.rt       = id_rt;
        ex_d.rs_used  = id_rs_used;
        ex_d.rt_used  = id_rt_used;
        ex_d.rd       = id_rd;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
      end else begin
        ex_d = '0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random traffic against a behavioural model of
// the instructions in flight. Two DUTs share stimulus: EX-resolved and ID-resolved branches.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RegW    = 4;
  localparam int unsigned ZeroReg = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            id_valid;
  logic [RegW-1:0] id_rs;
  logic [RegW-1:0] id_rt;
  logic            id_rs_used;
  logic            id_rt_used;
  logic [RegW-1:0] id_rd;
  logic            id_regwrite;
  logic            id_memread;
  logic            id_hlt;
  logic            br_taken;
  logic            mem_ready;

  logic [1:0] stall_w, bub_w, flush_w, frz_w, halt_w;
  logic [3:0] frs_w, frt_w;

  // Values sampled by the last step, for directed checks.
  logic [1:0] o_stall, o_bub, o_flush, o_frz, o_halt;
  logic [3:0] o_frs, o_frt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pipe_hazard_ctrl #(
    .REG_ADDR_W (RegW),
    .ZERO_REG   (ZeroReg),
    .BR_RESOLVE (1)
  ) u_dut_ex (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_hlt      (id_hlt),
    .br_taken    (br_taken),
    .mem_ready   (mem_ready),
    .stall_if_id (stall_w[0]),
    .bubble_ex   (bub_w[0]),
    .flush_if_id (flush_w[0]),
    .freeze      (frz_w[0]),
    .fwd_rs_sel  (frs_w[1:0]),
    .fwd_rt_sel  (frt_w[1:0]),
    .halted      (halt_w[0])
  );

  pipe_hazard_ctrl #(
    .REG_ADDR_W (RegW),
    .ZERO_REG   (ZeroReg),
    .BR_RESOLVE (0)
  ) u_dut_id (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_hlt      (id_hlt),
    .br_taken    (br_taken),
    .mem_ready   (mem_ready),
    .stall_if_id (stall_w[1]),
    .bubble_ex   (bub_w[1]),
    .flush_if_id (flush_w[1]),
    .freeze      (frz_w[1]),
    .fwd_rs_sel  (frs_w[3:2]),
    .fwd_rt_sel  (frt_w[3:2]),
    .halted      (halt_w[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model: the instructions occupying EX, MEM, WB ----------------
  typedef struct {
    bit v;
    int rs;
    int rt;
    bit rs_u;
    bit rt_u;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  instr_t pipe [2][3];  // [dut][0=EX, 1=MEM, 2=WB]
  int     mstate [2];   // 0 running, 1 draining, 2 halted
  bit     primed = 1'b0;

  function automatic instr_t empty_instr();
    instr_t t;
    t.v = 0; t.rs = 0; t.rt = 0; t.rs_u = 0; t.rt_u = 0; t.rd = 0; t.rw = 0; t.mr = 0;
    return t;
  endfunction

  function automatic instr_t id_instr();
    instr_t t;
    t.v = 1; t.rs = int'(id_rs); t.rt = int'(id_rt); t.rs_u = id_rs_used; t.rt_u = id_rt_used;
    t.rd = int'(id_rd); t.rw = id_regwrite; t.mr = id_memread;
    return t;
  endfunction

  function automatic bit reg_live(input int r);
    return (ZeroReg == 0) || (r != 0);
  endfunction

  // Nearest older writer of r: MEM gives 2, WB gives 1, none gives 0.
  function automatic int fwd_src(input int k, input bit used, input int r);
    if (!used || !reg_live(r)) return 0;
    for (int s = 1; s <= 2; s++) begin
      if (pipe[k][s].v && pipe[k][s].rw && pipe[k][s].rd == r) return (s == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic void model_eval(input int k, output bit stall, output bit bub,
                                     output bit flush, output bit frz, output int frs,
                                     output int frt, output bit drain);
    instr_t ex;
    bit taken, hazard;
    ex = pipe[k][0];
    stall = 0; bub = 0; flush = 0; frz = 0; frs = 0; frt = 0; drain = 0;
    if (rst) return;
    frs = fwd_src(k, ex.v && ex.rs_u, ex.rs);
    frt = fwd_src(k, ex.v && ex.rt_u, ex.rt);
    if (!mem_ready) begin
      frz = 1;
      return;
    end
    if (mstate[k] != 0) begin
      stall = 1;
      bub   = 1;
      return;
    end
    taken  = (k == 0) ? br_taken : (br_taken && id_valid);
    hazard = ex.v && ex.mr && ex.rw && reg_live(ex.rd) && id_valid &&
             ((id_rs_used && int'(id_rs) == ex.rd) || (id_rt_used && int'(id_rt) == ex.rd));
    if (taken) begin
      flush = 1;
      bub   = (k == 0);
    end else if (hazard) begin
      stall = 1;
      bub   = 1;
    end else if (id_valid && id_hlt) begin
      stall = 1;
      bub   = 1;
      drain = 1;
    end
  endfunction

  function automatic void model_advance(input int k, input bit bub, input bit flush,
                                        input bit drain);
    if (rst) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = empty_instr();
      mstate[k] = 0;
      return;
    end
    if (!mem_ready) return;
    if (mstate[k] == 1 && !pipe[k][1].v) mstate[k] = 2;
    else if (drain) mstate[k] = 1;
    pipe[k][2] = pipe[k][1];
    pipe[k][1] = pipe[k][0];
    if (id_valid && !bub && !flush) pipe[k][0] = id_instr();
    else pipe[k][0] = empty_instr();
  endfunction

  // One clock: sample after inputs settle, compare to model, advance model, cross the edge.
  task automatic step();
    bit e_stall, e_bub, e_flush, e_frz, e_drain;
    int e_frs, e_frt;
    #1;
    o_stall = stall_w; o_bub = bub_w; o_flush = flush_w; o_frz = frz_w; o_halt = halt_w;
    o_frs = frs_w; o_frt = frt_w;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, e_stall, e_bub, e_flush, e_frz, e_frs, e_frt, e_drain);
      check_val($sformatf("stall[%0d]", k), 32'(stall_w[k]), 32'(e_stall));
      check_val($sformatf("bubble[%0d]", k), 32'(bub_w[k]), 32'(e_bub));
      check_val($sformatf("flush[%0d]", k), 32'(flush_w[k]), 32'(e_flush));
      check_val($sformatf("freeze[%0d]", k), 32'(frz_w[k]), 32'(e_frz));
      check_val($sformatf("fwd_rs[%0d]", k), 32'(k == 0 ? frs_w[1:0] : frs_w[3:2]), e_frs);
      check_val($sformatf("fwd_rt[%0d]", k), 32'(k == 0 ? frt_w[1:0] : frt_w[3:2]), e_frt);
      if (primed) check_val($sformatf("halted[%0d]", k), 32'(halt_w[k]), 32'(mstate[k] == 2));
      model_advance(k, e_bub, e_flush, e_drain);
    end
    if (rst) primed = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    rst = 0; id_valid = 0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
    id_rd = '0; id_regwrite = 0; id_memread = 0; id_hlt = 0; br_taken = 0; mem_ready = 1;
  endtask

  task automatic drive_instr(input int rd, input bit rw, input bit mr, input int rs,
                             input bit rs_u, input int rt, input bit rt_u);
    drive_idle();
    id_valid = 1; id_rd = RegW'(rd); id_regwrite = rw; id_memread = mr;
    id_rs = RegW'(rs); id_rs_used = rs_u; id_rt = RegW'(rt); id_rt_used = rt_u;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  // Two ALU ops fill EX and MEM, then HLT; returns steps until halted is seen.
  task automatic do_halt(input int nfreeze, output int cnt);
    drive_instr(1, 1, 0, 0, 0, 0, 0);
    step();
    drive_instr(2, 1, 0, 0, 0, 0, 0);
    step();
    drive_idle();
    id_valid = 1; id_hlt = 1;
    step();
    check_val("hlt_stall", 32'(o_stall[0]), 1);
    check_val("hlt_bubble", 32'(o_bub[0]), 1);
    drive_idle();
    cnt = 0;
    do begin
      mem_ready = (cnt < nfreeze) ? 1'b0 : 1'b1;
      step();
      cnt++;
    end while (!o_halt[0] && cnt < 20);
    drive_idle();
  endtask

  task automatic fwd_seq(input int rd_a, input int rd_b, input int src, input int exp);
    drive_instr(rd_a, 1, 0, 0, 0, 0, 0);
    step();
    drive_instr(rd_b, 1, 0, 0, 0, 0, 0);
    step();
    drive_instr(9, 1, 0, src, 1, 0, 0);
    step();
    drive_idle();
    step();
    check_val($sformatf("fwd_seq_%0d_%0d", rd_a, rd_b), 32'(o_frs[1:0]), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    drive_idle();
    rst = 1;
    @(negedge clk);
    step();
    rst = 0;
    step();
    check_val("reset_outputs", 32'({o_stall, o_bub, o_flush, o_frz, o_halt, o_frs, o_frt}), 0);

    // Forwarding: MEM beats WB, WB alone, r0 never forwards.
    fwd_seq(3, 3, 3, 2);
    fwd_seq(3, 7, 3, 1);
    fwd_seq(0, 0, 0, 0);

    // Load-use: one stall, then WB forward two cycles later.
    do_reset();
    drive_instr(5, 1, 1, 1, 1, 0, 0);
    step();
    drive_instr(6, 1, 0, 2, 1, 5, 1);
    step();
    check_val("lu_stall", 32'(o_stall[0]), 1);
    check_val("lu_bubble", 32'(o_bub[0]), 1);
    step();
    check_val("lu_stall_once", 32'(o_stall[0]), 0);
    drive_idle();
    step();
    check_val("lu_fwd_rt", 32'(o_frt[1:0]), 1);

    // Unused source does not stall.
    do_reset();
    drive_instr(5, 1, 1, 1, 1, 0, 0);
    step();
    drive_instr(6, 1, 0, 2, 1, 5, 0);
    step();
    check_val("lu_unused", 32'(o_stall[0]), 0);

    // Taken branch coinciding with load-use: flush wins.
    do_reset();
    drive_instr(5, 1, 1, 1, 1, 0, 0);
    step();
    drive_instr(6, 1, 0, 2, 1, 5, 1);
    br_taken = 1;
    step();
    check_val("br_ex_flush", 32'(o_flush[0]), 1);
    check_val("br_ex_bubble", 32'(o_bub[0]), 1);
    check_val("br_ex_stall", 32'(o_stall[0]), 0);
    check_val("br_id_flush", 32'(o_flush[1]), 1);
    check_val("br_id_bubble", 32'(o_bub[1]), 0);
    check_val("br_id_stall", 32'(o_stall[1]), 0);

    // Freeze for 4 cycles during a load-use hazard, then exactly one stall.
    do_reset();
    drive_instr(5, 1, 1, 1, 1, 0, 0);
    step();
    drive_instr(6, 1, 0, 2, 1, 5, 1);
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("frz_freeze", 32'(o_frz[0]), 1);
      check_val("frz_stall", 32'(o_stall[0]), 0);
    end
    mem_ready = 1;
    step();
    check_val("frz_release_stall", 32'(o_stall[0]), 1);
    step();
    check_val("frz_release_once", 32'(o_stall[0]), 0);

    // Halt latency: 3 cycles, 5 with two frozen cycles in the drain.
    do_reset();
    do_halt(0, cnt);
    check_val("halt_latency", cnt, 3);
    do_reset();
    do_halt(2, cnt);
    check_val("halt_latency_frozen", cnt, 5);

    // Reset during the drain, then halt again.
    do_reset();
    drive_instr(1, 1, 0, 0, 0, 0, 0);
    step();
    drive_instr(2, 1, 0, 0, 0, 0, 0);
    step();
    drive_idle();
    id_valid = 1; id_hlt = 1;
    step();
    drive_idle();
    step();
    rst = 1;
    step();
    rst = 0;
    step();
    check_val("rst_drain_halted", 32'(o_halt[0]), 0);
    check_val("rst_drain_outputs", 32'({o_stall[0], o_bub[0], o_flush[0], o_frs[1:0]}), 0);
    do_halt(0, cnt);
    check_val("halt_after_rst", cnt, 3);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_idle();
      rst = ($urandom_range(0, 299) == 0) ||
            (mstate[0] == 2 && $urandom_range(0, 3) == 0);
      mem_ready   = ($urandom_range(0, 99) < 85);
      br_taken    = ($urandom_range(0, 99) < 6);
      id_valid    = ($urandom_range(0, 99) < 80);
      id_rs       = RegW'($urandom_range(0, 3));
      id_rt       = RegW'($urandom_range(0, 3));
      id_rd       = RegW'($urandom_range(0, 3));
      id_rs_used  = ($urandom_range(0, 99) < 75);
      id_rt_used  = ($urandom_range(0, 99) < 60);
      id_regwrite = ($urandom_range(0, 99) < 70);
      id_memread  = id_regwrite && ($urandom_range(0, 99) < 35);
      id_hlt      = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
